// File: rtl/fnd_display_arbiter_if.sv
// Bundle between the two digit sources (master) and the FND arbiter (slave).
// Carries the request/data lines in and the grant, frame pulse and pin drive out.
interface fnd_display_arbiter_if;
   logic [1:0]  req;
   logic [31:0] data0;
   logic [31:0] data1;
   logic [1:0]  grant;
   logic        frame_done;
   logic [6:0]  seg;
   logic [7:0]  an;

   modport master (
      output req, data0, data1,
      input  grant, frame_done, seg, an
   );

   modport slave (
      input  req, data0, data1,
      output grant, frame_done, seg, an
   );
endinterface

// File: rtl/fnd_display_arbiter.sv
// Shares the 8-digit FND between two BCD sources, re-arbitrating only at frame
// boundaries (round-robin with minimum hold) and owning the blanked refresh scan.
module fnd_display_arbiter #(
   parameter int REFRESH_DIV = 1000,
   parameter int BLANK_CYC   = 50,
   parameter int HOLD_FRAMES = 4
) (
   input logic                  sysclk,
   input logic                  rstn,
   fnd_display_arbiter_if.slave disp
);

   localparam int CNT_W  = $clog2(REFRESH_DIV);
   localparam int HOLD_W = $clog2(HOLD_FRAMES) + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]  BLANK_LIM = CNT_W'(BLANK_CYC);
   localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(HOLD_FRAMES - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

   // Owner encodings double as the one-hot grant value.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] OWN0 = 2'b01;
   localparam logic [1:0] OWN1 = 2'b10;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        dsel_q, dsel_d;
   logic [1:0]        state_q, state_d;
   logic [1:0]        grant_q;
   logic [31:0]       fb_q, fb_d;
   logic              last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              frame_done_q;
   logic              slotTick;
   logic              frameEnd;
   logic              blank;
   logic [3:0]        digit;
   logic [6:0]        glyph;

   assign slotTick = (cnt_q == CNT_LAST);
   assign frameEnd = slotTick && (dsel_q == 3'd7);
   assign cnt_d    = slotTick ? '0 : cnt_q + 1'b1;
   assign dsel_d   = slotTick ? dsel_q + 3'd1 : dsel_q;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (disp.req == 2'b11)  state_d = last_q ? OWN0 : OWN1;
            else if (disp.req[0])   state_d = OWN0;
            else if (disp.req[1])   state_d = OWN1;
         end
         OWN0: begin
            if (!disp.req[0])                        state_d = disp.req[1] ? OWN1 : IDLE;
            else if (disp.req[1] && hold_q >= HOLD_LIM) state_d = OWN1;
         end
         OWN1: begin
            if (!disp.req[1])                        state_d = disp.req[0] ? OWN0 : IDLE;
            else if (disp.req[0] && hold_q >= HOLD_LIM) state_d = OWN0;
         end
         default: state_d = IDLE;
      endcase

      // A fresh owner restarts its hold count; a continuing owner accumulates it.
      if (state_d != IDLE && state_d != state_q) begin
         last_d = (state_d == OWN1);
         hold_d = '0;
      end else if (state_d != IDLE && state_d == state_q && hold_q != HOLD_SAT) begin
         hold_d = hold_q + 1'b1;
      end

      case (state_d)
         OWN0:    fb_d = disp.data0;
         OWN1:    fb_d = disp.data1;
         default: fb_d = '0;
      endcase
   end

   always_ff @(posedge sysclk or negedge rstn) begin
      if (!rstn) begin
         cnt_q        <= '0;
         dsel_q       <= '0;
         state_q      <= IDLE;
         grant_q      <= 2'b00;
         fb_q         <= '0;
         last_q       <= 1'b1;
         hold_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         dsel_q       <= dsel_d;
         frame_done_q <= frameEnd;
         if (frameEnd) begin
            state_q <= state_d;
            grant_q <= state_d;
            fb_q    <= fb_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
         end
      end
   end

   // Digit fetch and active-low glyph lookup; codes 10-15 render blank.
   always_comb begin
      digit = fb_q[{dsel_q, 2'b00} +: 4];
      case (digit)
         4'd0:    glyph = 7'h40;
         4'd1:    glyph = 7'h79;
         4'd2:    glyph = 7'h24;
         4'd3:    glyph = 7'h30;
         4'd4:    glyph = 7'h19;
         4'd5:    glyph = 7'h12;
         4'd6:    glyph = 7'h02;
         4'd7:    glyph = 7'h78;
         4'd8:    glyph = 7'h00;
         4'd9:    glyph = 7'h10;
         default: glyph = 7'h7F;
      endcase
   end

   assign blank = (state_q == IDLE) || ((BLANK_CYC != 0) && (cnt_q < BLANK_LIM));

   assign disp.an         = blank ? 8'hFF : ~(8'b1 << dsel_q);
   assign disp.seg        = blank ? 7'h7F : glyph;
   assign disp.grant      = grant_q;
   assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Randomized and directed bench for fnd_display_arbiter, checked each cycle
// against a frame-position/ownership reference model.
module tb_fnd_display_arbiter;

   localparam int RD    = 10;
   localparam int BC    = 2;
   localparam int HF    = 2;
   localparam int FRAME = 8 * RD;

   logic sysclk = 1'b0;
   logic rstn;

   fnd_display_arbiter_if dispIf ();

   fnd_display_arbiter #(
      .REFRESH_DIV (RD),
      .BLANK_CYC   (BC),
      .HOLD_FRAMES (HF)
   ) dut (
      .sysclk (sysclk),
      .rstn   (rstn),
      .disp   (dispIf)
   );

   always #5 sysclk = ~sysclk;

   int total = 0;
   int bad   = 0;

   // Model: cycles since reset, current owner (-1 idle), last owner,
   // frames shown by the current owner, and the latched frame digits.
   int          pos;
   int          owner;
   int          lastOwner;
   int          heldFrames;
   logic [31:0] fbModel;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (pos=%0d t=%0t)", tag, actual, expected, pos, $time);
      end
   endtask

   function automatic logic [6:0] segsOn(input int d);
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   task automatic resetModel();
      pos        = 0;
      owner      = -1;
      lastOwner  = 1;
      heldFrames = 0;
      fbModel    = '0;
   endtask

   task automatic modelBoundary();
      int nextOwner;
      int other;
      nextOwner = owner;
      if (owner < 0) begin
         if (dispIf.req == 2'b11)  nextOwner = (lastOwner == 1) ? 0 : 1;
         else if (dispIf.req[0])   nextOwner = 0;
         else if (dispIf.req[1])   nextOwner = 1;
      end else begin
         other = 1 - owner;
         if (!dispIf.req[owner])                           nextOwner = dispIf.req[other] ? other : -1;
         else if (dispIf.req[other] && heldFrames >= HF)   nextOwner = other;
      end
      if (nextOwner >= 0 && nextOwner != owner) begin
         lastOwner  = nextOwner;
         heldFrames = 1;
      end else if (nextOwner >= 0) begin
         heldFrames++;
      end
      owner   = nextOwner;
      fbModel = (owner == 0) ? dispIf.data0 : (owner == 1) ? dispIf.data1 : 32'h0;
   endtask

   task automatic checkAll();
      int slot, off, d;
      logic [7:0] expAn;
      logic [6:0] expSeg;
      logic [1:0] expGrant;
      slot = (pos % FRAME) / RD;
      off  = pos % RD;
      if (owner < 0 || off < BC) begin
         expAn  = 8'hFF;
         expSeg = 7'h7F;
      end else begin
         expAn  = 8'hFF & ~(8'(1) << slot);
         d      = int'((fbModel >> (4 * slot)) & 32'hF);
         expSeg = (d <= 9) ? ~segsOn(d) : 7'h7F;
      end
      expGrant = (owner < 0) ? 2'b00 : (owner == 0) ? 2'b01 : 2'b10;
      checkOutput("an", 32'(dispIf.an), 32'(expAn));
      checkOutput("seg", 32'(dispIf.seg), 32'(expSeg));
      checkOutput("grant", 32'(dispIf.grant), 32'(expGrant));
      checkOutput("frame_done", 32'(dispIf.frame_done), 32'((pos > 0) && (pos % FRAME == 0)));
   endtask

   task automatic stepCycle();
      @(posedge sysclk);
      if (pos % FRAME == FRAME - 1) modelBoundary();
      pos++;
      #1;
      checkAll();
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   task automatic applyStimulus(input logic [1:0] req, input logic [31:0] d0, input logic [31:0] d1);
      dispIf.req   = req;
      dispIf.data0 = d0;
      dispIf.data1 = d1;
   endtask

   // Asynchronous reset: outputs must clear within the same cycle.
   task automatic doReset();
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("rst_an", 32'(dispIf.an), 32'hFF);
      checkOutput("rst_seg", 32'(dispIf.seg), 32'h7F);
      checkOutput("rst_grant", 32'(dispIf.grant), 32'h0);
      checkOutput("rst_frame_done", 32'(dispIf.frame_done), 32'h0);
      @(negedge sysclk);
      @(negedge sysclk);
      rstn = 1'b1;
      resetModel();
   endtask

   initial begin
      rstn = 1'b1;
      resetModel();
      applyStimulus(2'b00, 32'h0, 32'h0);
      doReset();

      // Idle display with periodic frame pulses.
      runCycles(500);

      // Single requester from reset.
      applyStimulus(2'b00, 32'h87654321, 32'h0);
      doReset();
      applyStimulus(2'b01, 32'h87654321, 32'h0);
      runCycles(3 * FRAME);

      // Both requesting: alternating ownership after the hold time.
      doReset();
      applyStimulus(2'b11, 32'h13572468, 32'h98765432);
      runCycles(6 * FRAME);

      // Owner drops mid-frame with the other waiting, then with nobody waiting.
      doReset();
      applyStimulus(2'b01, 32'h11223344, 32'h55667788);
      runCycles(FRAME + 30);
      applyStimulus(2'b10, 32'h11223344, 32'h55667788);
      runCycles(2 * FRAME);
      doReset();
      applyStimulus(2'b01, 32'h11223344, 32'h55667788);
      runCycles(FRAME + 30);
      applyStimulus(2'b00, 32'h11223344, 32'h55667788);
      runCycles(2 * FRAME);

      // Mid-frame data change stays invisible until the boundary.
      doReset();
      applyStimulus(2'b01, 32'h11111111, 32'h0);
      runCycles(FRAME + 37);
      applyStimulus(2'b01, 32'h22222222, 32'h0);
      runCycles(2 * FRAME);

      // Non-BCD digit blanks its slot; reset lands mid-slot at cnt=5.
      doReset();
      applyStimulus(2'b01, 32'h8765A321, 32'h0);
      runCycles(FRAME + 3 * RD);
      while (pos % RD != 5) stepCycle();
      doReset();
      runCycles(FRAME);

      // Randomized request/data churn with occasional resets and short pulses.
      for (int it = 0; it < 40; it++) begin
         applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom);
         runCycles($urandom_range(3, 200));
         if ($urandom_range(0, 9) == 0) doReset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
